pri_req_gen: RTL and testbench



---
 rtl/pri_pkg.sv | 15 +
 rtl/pri_enc.sv | 15 +
 rtl/pri_req_gen.sv | 125 ++++++++++++
 tb/tb_pri_req_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pri_pkg.sv
// Shared defaults, FSM state encoding and round timeout for the priority request generator.
package pri_pkg;
  localparam int N_DEF   = 4;
  localparam int P_DEF   = 16;
  localparam int PW_DEF  = $clog2(P_DEF);
  localparam int CW_DEF  = 4;
  localparam int TIMEOUT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;
endpackage

// File: rtl/pri_enc.sv
// Highest-nonzero-level encoder over one port's pending-request counters; 0 when all are empty.
module pri_enc import pri_pkg::*; #(
  parameter  int P  = P_DEF,
  parameter  int CW = CW_DEF,
  localparam int PW = $clog2(P)
) (
  input  logic [P-1:1][CW-1:0] cnt,
  output logic [PW-1:0]        lvl
);
  always_comb begin
    lvl = '0;
    for (int l = 1; l < P; l++)
      if (cnt[l] != '0) lvl = PW'(l);
  end
endmodule

// File: rtl/pri_req_gen.sv
// Per-port/per-level request counters feeding a pri_sel comparison round, with round-robin
// tie-break among the returned winners and a watchdog on the pri_sel response.
module pri_req_gen import pri_pkg::*; #(
  parameter  int N  = N_DEF,
  parameter  int P  = P_DEF,
  parameter  int CW = CW_DEF,
  localparam int PW = $clog2(P),
  localparam int NW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_valid,
  input  logic [NW-1:0]        push_port,
  input  logic [PW-1:0]        push_pri,
  output logic                 push_ready,
  output logic [N-1:0][PW-1:0] pri_out,
  output logic                 update,
  input  logic                 ready,
  input  logic [N-1:0]         req_in,
  output logic                 grant_valid,
  output logic [NW-1:0]        grant_port,
  output logic [PW-1:0]        grant_pri,
  output logic                 err
);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t                      state;
  logic [N-1:0][P-1:1][CW-1:0] cnt;
  logic [N-1:0][P-1:1]         inc, dec;
  logic [N-1:0][PW-1:0]        lvl, pri_q;
  logic [N-1:0]                win_q;
  logic [NW-1:0]               rr_ptr, winner, idx;
  logic [WW-1:0]               wd;
  logic                        push_acc, found;

  for (genvar i = 0; i < N; i++) begin : g_enc
    pri_enc #(.P(P), .CW(CW)) u_enc (.cnt(cnt[i]), .lvl(lvl[i]));
  end

  always_comb begin
    push_ready = 1'b0;
    for (int i = 0; i < N; i++)
      for (int l = 1; l < P; l++)
        if (push_port == NW'(i) && push_pri == PW'(l)) push_ready = (cnt[i][l] != CNT_MAX);
  end
  assign push_acc = push_valid & push_ready;

  // Scan win_q starting at rr_ptr, wrapping at N.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && win_q[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
      idx = (idx == NW'(N-1)) ? '0 : idx + 1'b1;
    end
  end

  assign update      = (state == ST_ISSUE);
  assign err         = (state == ST_WAIT) && !ready && (wd == WW'(TIMEOUT-1));
  assign grant_valid = (state == ST_COMMIT);
  assign grant_port  = grant_valid ? winner : '0;
  assign grant_pri   = grant_valid ? pri_q[winner] : '0;
  assign pri_out     = pri_q;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < N; i++)
      for (int l = 1; l < P; l++) begin
        inc[i][l] = push_acc && push_port == NW'(i) && push_pri == PW'(l);
        dec[i][l] = grant_valid && winner == NW'(i) && pri_q[i] == PW'(l);
      end
  end

  // A simultaneous push and commit on one counter cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else
      for (int i = 0; i < N; i++)
        for (int l = 1; l < P; l++)
          if (inc[i][l] && !dec[i][l])      cnt[i][l] <= cnt[i][l] + 1'b1;
          else if (dec[i][l] && !inc[i][l]) cnt[i][l] <= cnt[i][l] - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      pri_q  <= '0;
      win_q  <= '0;
      rr_ptr <= '0;
      wd     <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (|lvl) begin
            pri_q <= lvl;
            state <= ST_ISSUE;
          end
        ST_ISSUE: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT:
          if (ready) begin
            win_q <= req_in;
            state <= (req_in != '0) ? ST_COMMIT : ST_IDLE;
          end else if (wd == WW'(TIMEOUT-1)) begin
            state <= ST_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        ST_COMMIT: begin
          rr_ptr <= (winner == NW'(N-1)) ? '0 : winner + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pri_req_gen.sv
// Scoreboard bench: reference counters and round-robin pointer model the request rules,
// a pri_sel emulator answers each update, and the negedge monitor checks every output.
module tb_pri_req_gen;
  import pri_pkg::*;
  localparam int N = 4, P = 16, PW = 4, CW = 4, NW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0, reset = 1'b0, push_valid = 1'b0, ready = 1'b0;
  logic [NW-1:0]        push_port = '0;
  logic [PW-1:0]        push_pri = '0;
  logic [N-1:0]         req_in = '0;
  logic                 push_ready, update, grant_valid, err;
  logic [N-1:0][PW-1:0] pri_out, exp_pri;
  logic [NW-1:0]        grant_port;
  logic [PW-1:0]        grant_pri;

  pri_req_gen #(.N(N), .P(P), .CW(CW)) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_port(push_port),
    .push_pri(push_pri), .push_ready(push_ready), .pri_out(pri_out), .update(update),
    .ready(ready), .req_in(req_in), .grant_valid(grant_valid), .grant_port(grant_port),
    .grant_pri(grant_pri), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int port; int pri; } grant_t;

  int     vecs = 0, errs = 0;
  int     mcnt[N][P], snap_cand[N][P], snap_lvl[N];
  int     mrr = 0;
  bit     acc_pend = 0, dec_pend = 0;
  int     acc_port, acc_pri, dec_port, dec_pri;
  bit     em_active = 0, em_hold = 0, withhold_all = 0, rand_hold = 0;
  int     em_cnt = 0, idle_cyc = 0, err_seen = 0;
  int     exp_rdy, best, mask, w, any;
  grant_t exp_q[$], g;
  int     glog[$];

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int top_of_snap(input int i);
    for (int l = P - 1; l >= 1; l--) if (snap_cand[i][l] != 0) return l;
    return 0;
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < N; i++)
      for (int l = 1; l < P; l++) if (mcnt[i][l] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference counters advance on the clock edge using decisions taken at the prior negedge.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++)
        for (int l = 0; l < P; l++) begin mcnt[i][l] = 0; snap_cand[i][l] = 0; end
    end else begin
      snap_cand = mcnt;
      if (acc_pend) mcnt[acc_port][acc_pri] += 1;
      if (dec_pend) mcnt[dec_port][dec_pri] -= 1;
    end
    acc_pend = 0;
    dec_pend = 0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_update", update, 0);
      chk("rst_grant_valid", grant_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_grant_port", grant_port, 0);
      chk("rst_grant_pri", grant_pri, 0);
      chk("rst_pri_out", int'(pri_out), 0);
      em_active = 0; exp_q.delete(); ready = 0; req_in = '0; idle_cyc = 0; mrr = 0;
    end else begin
      ready  = 0;
      req_in = '0;
      exp_rdy = (push_pri != 0 && mcnt[push_port][push_pri] < CMAX) ? 1 : 0;
      chk("push_ready", push_ready, exp_rdy);
      if (push_valid && exp_rdy != 0) begin
        acc_pend = 1; acc_port = push_port; acc_pri = push_pri;
      end
      if (em_active) em_cnt++;
      chk("err", err, (em_active && em_hold && em_cnt == TIMEOUT) ? 1 : 0);
      if (err) err_seen++;
      if (em_active && em_hold && em_cnt == TIMEOUT) em_active = 0;

      if (em_active && !em_hold && em_cnt == 5) begin
        chk("grant_valid", grant_valid, 1);
        g = exp_q.pop_front();
        chk("grant_port", grant_port, g.port);
        chk("grant_pri", grant_pri, g.pri);
        glog.push_back(int'(grant_port));
        dec_pend = 1; dec_port = g.port; dec_pri = g.pri;
        mrr = (g.port + 1) % N;
        em_active = 0;
      end else begin
        chk("grant_valid_idle", grant_valid, 0);
      end

      if (update) begin
        chk("update_overlap", em_active, 0);
        any = 0;
        for (int i = 0; i < N; i++) begin
          snap_lvl[i] = top_of_snap(i);
          exp_pri[i]  = PW'(snap_lvl[i]);
          if (snap_lvl[i] != 0) any = 1;
        end
        chk("update_has_work", any, 1);
        em_active = 1; em_cnt = 0; idle_cyc = 0;
        em_hold = withhold_all || (rand_hold && $urandom_range(7) == 0);
      end else if (!em_active && model_busy()) begin
        idle_cyc++;
        if (idle_cyc == 3) begin
          chk("update_latency", idle_cyc, 2);
          idle_cyc = 0;
        end
      end else if (!model_busy()) begin
        idle_cyc = 0;
      end

      if (em_active) chk("pri_out", int'(pri_out), int'(exp_pri));

      // pri_sel stand-in: ports tied at the top level, answered in the 4th WAIT cycle.
      if (em_active && !em_hold && em_cnt == 4) begin
        best = 0;
        for (int i = 0; i < N; i++) if (snap_lvl[i] > best) best = snap_lvl[i];
        mask = 0;
        for (int i = 0; i < N; i++) if (snap_lvl[i] == best) mask |= (1 << i);
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && mask[(mrr + k) % N]) w = (mrr + k) % N;
        exp_q.push_back('{port: w, pri: snap_lvl[w]});
        ready  = 1;
        req_in = N'(mask);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push1(input int p, input int l);
    push_valid = 1; push_port = NW'(p); push_pri = PW'(l);
    step(1);
    push_valid = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    step(3);
    reset = 1;
    step(1);
  endtask

  task automatic drain(input int max_cyc);
    int busy;
    busy = 1;
    for (int c = 0; c < max_cyc && busy != 0; c++) begin
      busy = (em_active || model_busy() || acc_pend) ? 1 : 0;
      if (busy != 0) step(1);
    end
    chk("drain_done", busy, 0);
  endtask

  task automatic chk_seq(input string name, input int exp[$]);
    chk({name, "_len"}, glog.size(), exp.size());
    if (glog.size() == exp.size())
      for (int i = 0; i < exp.size(); i++) chk(name, glog[i], exp[i]);
  endtask

  initial begin
    int seen;
    step(3);
    reset = 1;
    step(1);

    // Top level wins first, then the lower port drains.
    glog.delete();
    push1(3, 9); push1(1, 5);
    drain(200);
    chk_seq("seq_levels", '{3, 1});

    // Equal levels on ports 0 and 2 alternate round-robin from rr_ptr 0.
    do_reset(); glog.delete();
    push1(0, 7); push1(2, 7); push1(0, 7); push1(2, 7);
    drain(300);
    chk_seq("seq_rr", '{0, 2, 0, 2});
    step(20);
    chk("idle_after_drain", glog.size(), 4);

    // Saturate one counter while every round times out.
    do_reset(); glog.delete(); err_seen = 0;
    withhold_all = 1;
    for (int j = 1; j <= 16; j++) begin
      if (j == 15) chk("sat_ready15", push_ready, 1);
      if (j == 16) chk("sat_ready16", push_ready, 0);
      push1(2, 3);
    end
    step(20);
    chk("sat_no_grant", glog.size(), 0);
    chk("sat_err_seen", (err_seen > 0) ? 1 : 0, 1);
    withhold_all = 0;
    drain(400);
    chk("sat_grants", glog.size(), 15);

    // Push that lands in COMMIT on the counter being granted.
    do_reset(); glog.delete();
    push1(0, 4);
    seen = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      if (ready) seen = 1; else step(1);
    end
    chk("commit_wait", seen, 1);
    push1(0, 4);
    drain(100);
    chk_seq("seq_commit_push", '{0, 0});

    // Reset asserted while waiting on pri_sel.
    do_reset(); glog.delete();
    push1(1, 6);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (update) seen = 1; else step(1);
    end
    chk("rst_mid_update", seen, 1);
    step(2);
    reset = 0;
    #1;
    chk("rst_async_update", update, 0);
    chk("rst_async_pri_out", int'(pri_out), 0);
    chk("rst_async_grant", grant_valid, 0);
    step(3);
    reset = 1;
    step(20);
    chk("rst_mid_no_grant", glog.size(), 0);

    // Randomised traffic with occasional missing responses.
    rand_hold = 1;
    for (int c = 0; c < 400; c++) begin
      push_valid = ($urandom_range(2) == 0);
      push_port  = NW'($urandom_range(N - 1));
      push_pri   = PW'($urandom_range(P - 1));
      step(1);
    end
    push_valid = 0;
    rand_hold  = 0;
    drain(4000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end
endmodule
